load_extend_pipe: RTL

//  Two-stage pipelined load/immediate formatter. Replaces the fixed 8/16->32 extender.

---
 rtl/ldx_pkg.sv | 26 ++
 rtl/ldx_lane_sel.sv | 34 +++
 rtl/load_extend_pipe.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ldx_pkg.sv
// ldx_pkg: shared types and constants for the load/immediate extension pipe.
//   ldx_mode_t   : 2-bit lane-size / source selector
//   LDX_BYTE/HALF/WORD/IMM : encodings of ldx_mode_t
//   ldx_stage_t  : stage-1 pipeline register contents (valid, mode, sign, misalign, lane)
//   LDX_DATA_W   : lane width carried in ldx_stage_t; the DATA_W parameter of
//                  load_extend_pipe must equal this value.
package ldx_pkg;

    localparam int LDX_DATA_W = 32;

    typedef logic [1:0] ldx_mode_t;

    localparam ldx_mode_t LDX_BYTE = 2'b00;
    localparam ldx_mode_t LDX_HALF = 2'b01;
    localparam ldx_mode_t LDX_WORD = 2'b10;
    localparam ldx_mode_t LDX_IMM  = 2'b11;

    typedef struct packed {
        logic                  valid;
        ldx_mode_t             mode;
        logic                  sgn;       // 1 = sign-extend in stage 2
        logic                  misalign;
        logic [LDX_DATA_W-1:0] lane;      // selected lane, zero-filled above its width
    } ldx_stage_t;

endpackage

// File: rtl/ldx_lane_sel.sv
// ldx_lane_sel: combinational lane picker feeding stage 1 of load_extend_pipe.
//   mode     in  : ldx_mode_t (byte / half / word / immediate)
//   offset   in  : little-endian byte offset into mem_data
//   mem_data in  : memory word
//   imm      in  : instruction immediate
//   lane     out : selected lane, right-aligned and zero-filled to DATA_W
// Word mode ignores the offset; half mode ignores offset[0].
module ldx_lane_sel
    import ldx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = 2
) (
    input  ldx_mode_t          mode,
    input  logic [OFF_W-1:0]   offset,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic [IMM_W-1:0]   imm,
    output logic [DATA_W-1:0]  lane
);

    always_comb begin
        lane = '0;
        case (mode)
            // Shift the addressed byte/half down to bit 0, then keep its width.
            LDX_BYTE: lane[7:0]       = 8'(mem_data >> {offset, 3'b000});
            LDX_HALF: lane[15:0]      = 16'(mem_data >> {offset[OFF_W-1:1], 4'b0000});
            LDX_WORD: lane            = mem_data;
            LDX_IMM:  lane[IMM_W-1:0] = imm;
            default:  lane            = '0;
        endcase
    end

endmodule

// File: rtl/load_extend_pipe.sv
// load_extend_pipe: two-stage load / immediate formatter between MDR/IR and the
// register-file write mux.
//   Stage 1 registers the lane chosen by ldx_lane_sel; stage 2 registers the
//   zero/sign-extended result.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset (synchronous release upstream)
//   in_valid / in_ready : input handshake
//   in_mode             : 00 byte, 01 half, 10 word, 11 immediate
//   in_signed           : 1 sign-extend, 0 zero-extend (no effect in word mode)
//   in_offset           : byte offset into in_mem_data
//   in_mem_data, in_imm : data sources
//   out_valid/out_ready : output handshake
//   out_data            : extended result
//   out_misalign        : misalignment flag of the delivered beat (0 unless enabled)
//   err_count           : saturating count of delivered misaligned beats
//                         (present only with LDX_MISALIGN_EN)
// Configuration macro: LDX_MISALIGN_EN enables misalign detection and err_count.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. valid never depends on ready; once raised, valid and its data hold until
// the transfer. in_ready depends only on internal state and out_ready, never on
// in_valid, so there is no combinational in_valid -> out_valid path.
module load_extend_pipe
    import ldx_pkg::*;
#(
    parameter int DATA_W = LDX_DATA_W,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic              in_signed,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
`ifdef LDX_MISALIGN_EN
    ,
    output logic [15:0]       err_count
`endif
);

    ldx_stage_t        s1;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_misalign;

    logic              s1_adv;
    logic              s2_adv;
    logic              accept;
    logic              mis_d;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] ext;

    // ---------------- flow control ----------------
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1.valid || s2_adv;
        in_ready = s1_adv;
        accept   = in_valid && in_ready;
    end

    // ---------------- stage 1: lane select ----------------
    ldx_lane_sel #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFF_W  (OFF_W)
    ) u_lane_sel (
        .mode     (in_mode),
        .offset   (in_offset),
        .mem_data (in_mem_data),
        .imm      (in_imm),
        .lane     (lane)
    );

`ifdef LDX_MISALIGN_EN
    assign mis_d = ((in_mode == LDX_HALF) && in_offset[0]) ||
                   ((in_mode == LDX_WORD) && (in_offset != '0));
`else
    // Constant 0: the misalign flops below reduce to constants in this build.
    assign mis_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
        end else if (s1_adv) begin
            s1.valid <= accept;
            // Payload only loads on accept; bubbles leave stale data behind.
            if (accept) begin
                s1.mode     <= in_mode;
                s1.sgn      <= in_signed;
                s1.misalign <= mis_d;
                s1.lane     <= lane;
            end
        end
    end

    // ---------------- stage 2: extension ----------------
    always_comb begin
        ext = '0;
        case (s1.mode)
            LDX_BYTE: ext = {{(DATA_W-8){s1.sgn & s1.lane[7]}}, s1.lane[7:0]};
            LDX_HALF: ext = {{(DATA_W-16){s1.sgn & s1.lane[15]}}, s1.lane[15:0]};
            LDX_WORD: ext = s1.lane;
            LDX_IMM:  ext = {{(DATA_W-IMM_W){s1.sgn & s1.lane[IMM_W-1]}},
                             s1.lane[IMM_W-1:0]};
            default:  ext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            s2_misalign <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1.valid;
            if (s1.valid) begin
                s2_data     <= ext;
                s2_misalign <= s1.misalign;
            end
        end
    end

    assign out_valid    = s2_valid;
    assign out_data     = s2_data;
    assign out_misalign = s2_misalign;

`ifdef LDX_MISALIGN_EN
    // Counts delivered misaligned beats, sticking at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_misalign && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
